ring_osc_trim_seq: RTL and testbench

RING_OSC_TRIM_SEQ -- requirements
Module: ring_osc_trim_seq

---
 rtl/ring_osc_trim_seq.sv | 159 +++++++++++++++
 tb/tb_ring_osc_trim_seq.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_osc_trim_seq.sv
// Slew-limited thermometer trim sequencer for a ring oscillator with external-trim bypass.
// Optional fractional dither of the trim word is enabled by RING_OSC_TRIM_DITHER_EN.
module ring_osc_trim_seq #(
    parameter int unsigned STAGES   = 13,
    parameter int unsigned CODE_W   = 5,
    parameter int unsigned SLEW_DIV = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                dco,
    input  logic [2*STAGES-1:0] ext_trim,
    input  logic [CODE_W-1:0]   target,
    input  logic                target_valid,
`ifdef RING_OSC_TRIM_DITHER_EN
    input  logic                target_frac,
`endif
    output logic                target_ready,
    output logic [2*STAGES-1:0] trim,
    output logic [CODE_W-1:0]   code,
    output logic                busy
);

    localparam int unsigned       TRIM_W   = 2 * STAGES;
    localparam logic [CODE_W-1:0] MAX_CODE = CODE_W'(TRIM_W);
    localparam logic [7:0]        RELOAD   = 8'(SLEW_DIV - 1);

    typedef enum logic [1:0] {StOff, StIdle, StSlew, StExt} state_e;

    state_e              state_q, state_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic [CODE_W-1:0]   tgt_q, tgt_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [TRIM_W-1:0]   trim_q, trim_d;
    logic                busy_q, busy_d;
    logic                accept;
    logic [CODE_W-1:0]   tgt_in;
    logic [CODE_W-1:0]   tgt_eff;
`ifdef RING_OSC_TRIM_DITHER_EN
    logic                frac_q, frac_d;
    logic                dith_q, dith_d;
`endif

    // Bits [0..STAGES-1] fill first, then [STAGES..], so the word is a plain thermometer.
    function automatic logic [TRIM_W-1:0] therm(input logic [CODE_W-1:0] k);
        logic [TRIM_W-1:0] t;
        for (int i = 0; i < int'(TRIM_W); i++) begin
            t[i] = (i < int'(k));
        end
        return t;
    endfunction

    assign target_ready = (state_q == StIdle) || (state_q == StSlew);
    assign accept       = target_valid && target_ready;
    assign tgt_in       = (target > MAX_CODE) ? MAX_CODE : target;
    assign tgt_eff      = accept ? tgt_in : tgt_q;

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        trim_d  = trim_q;
        busy_d  = busy_q;
`ifdef RING_OSC_TRIM_DITHER_EN
        frac_d  = frac_q;
        dith_d  = 1'b0;
`endif
        if (!enable) begin
            state_d = StOff;
            code_d  = '0;
            tgt_d   = '0;
            cnt_d   = '0;
            trim_d  = '0;
            busy_d  = 1'b0;
`ifdef RING_OSC_TRIM_DITHER_EN
            frac_d  = 1'b0;
`endif
        end else if (dco) begin
            state_d = StExt;
            trim_d  = ext_trim;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                StOff, StExt: begin
                    // Resume from the frozen code; a slew interrupted by bypass restarts its divider.
                    state_d = (code_q == tgt_q) ? StIdle : StSlew;
                    cnt_d   = RELOAD;
                end
                StIdle: begin
                    tgt_d = tgt_eff;
                    if (tgt_eff != code_q) begin
                        state_d = StSlew;
                        cnt_d   = RELOAD;
                    end
                end
                StSlew: begin
                    tgt_d = tgt_eff;
                    if (cnt_q == 8'd0) begin
                        cnt_d = RELOAD;
                        if (code_q < tgt_eff) begin
                            code_d = code_q + 1'b1;
                        end else if (code_q > tgt_eff) begin
                            code_d = code_q - 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                    state_d = (code_d == tgt_d) ? StIdle : StSlew;
                end
                default: state_d = StOff;
            endcase
`ifdef RING_OSC_TRIM_DITHER_EN
            if (accept) begin
                frac_d = target_frac;
            end
`endif
            trim_d = therm(code_d);
            busy_d = (code_d != tgt_d);
`ifdef RING_OSC_TRIM_DITHER_EN
            if (state_d == StIdle && frac_d && code_d < MAX_CODE) begin
                trim_d = dith_q ? therm(code_d) : therm(code_d + 1'b1);
                dith_d = ~dith_q;
            end
`endif
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StOff;
            code_q  <= '0;
            tgt_q   <= '0;
            cnt_q   <= '0;
            trim_q  <= '0;
            busy_q  <= 1'b0;
`ifdef RING_OSC_TRIM_DITHER_EN
            frac_q  <= 1'b0;
            dith_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
            trim_q  <= trim_d;
            busy_q  <= busy_d;
`ifdef RING_OSC_TRIM_DITHER_EN
            frac_q  <= frac_d;
            dith_q  <= dith_d;
`endif
        end
    end

    assign trim = trim_q;
    assign code = code_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_ring_osc_trim_seq.sv
// Directed bench for ring_osc_trim_seq: expected code steps are queued at stimulus time
// and checked (value, trim, busy, edge number) as the DUT steps.
module tb_ring_osc_trim_seq;

    localparam int SLEW = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        dco;
    logic [25:0] ext_trim;
    logic [4:0]  target;
    logic        target_valid;
    logic        target_ready;
    logic [25:0] trim;
    logic [4:0]  code;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    logic mon_on = 1'b0;

    typedef struct {
        int          code;
        logic [25:0] trim;
        logic        busy;
        int          cyc;
    } exp_t;

    exp_t q[$];

    ring_osc_trim_seq dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .dco          (dco),
        .ext_trim     (ext_trim),
        .target       (target),
        .target_valid (target_valid),
        .target_ready (target_ready),
        .trim         (trim),
        .code         (code),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [25:0] therm_exp(input int c);
        logic [26:0] t;
        t = (27'd1 << c) - 27'd1;
        return t[25:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_ramp(input int from, input int to, input int tgt, input int start);
        int   c;
        int   k;
        exp_t e;
        c = from;
        k = 0;
        while (c != to) begin
            c += (to > from) ? 1 : -1;
            k++;
            e.code = c;
            e.trim = therm_exp(c);
            e.busy = (c != tgt);
            e.cyc  = start + SLEW * k;
            q.push_back(e);
        end
    endtask

    task automatic offer(input int t, output int acc);
        @(negedge clock);
        target       = 5'(t);
        target_valid = 1'b1;
        acc          = cyc + 1;
        @(negedge clock);
        target_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        bit done;
        done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clock);
            #1;
            if (q.size() == 0 && !busy) done = 1;
        end
        checks++;
        if (!done) begin
            errors++;
            $error("FAIL %s_timeout: observed=pending %0d expected=0", tag, q.size());
        end
    endtask

    task automatic wait_code(input string tag, input int c, input int budget);
        bit done;
        done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clock);
            #1;
            if (int'(code) == c) done = 1;
        end
        checks++;
        if (!done) begin
            errors++;
            $error("FAIL %s_timeout: observed=%0d expected=%0d", tag, code, c);
        end
    endtask

    // Scoreboard: every code change must match the next queued step.
    logic [4:0]  prev_code = '0;
    logic [25:0] prev_trim = '0;
    always @(negedge clock) begin
        exp_t e;
        if (mon_on && code != prev_code) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_step: observed=%0d expected=none", code);
            end else begin
                e = q.pop_front();
                chk("step_code", 64'(code), 64'(e.code));
                chk("step_trim", 64'(trim), 64'(e.trim));
                chk("step_busy", 64'(busy), 64'(e.busy));
                chk("step_edge", 64'(cyc), 64'(e.cyc));
                chk("step_onebit", 64'($countones(trim ^ prev_trim)), 64'd1);
            end
        end
        prev_code = code;
        prev_trim = trim;
    end

    initial begin
        int acc;
        int s;
        reset        = 1'b1;
        enable       = 1'b0;
        dco          = 1'b0;
        ext_trim     = '0;
        target       = '0;
        target_valid = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_code", 64'(code), 64'd0);
        chk("rst_trim", 64'(trim), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(target_ready), 64'd0);

        reset  = 1'b0;
        enable = 1'b1;
        repeat (2) @(negedge clock);
        chk("idle_ready", 64'(target_ready), 64'd1);
        chk("idle_busy", 64'(busy), 64'd0);
        mon_on = 1'b1;

        // Ramp 0 -> 3: steps at +4, +8, +12
        offer(3, acc);
        push_ramp(0, 3, 3, acc);
        #1;
        chk("a_busy_rise", 64'(busy), 64'd1);
        wait_idle("a", 40);
        chk("a_code", 64'(code), 64'd3);
        chk("a_trim", 64'(trim), 64'h0000007);
        chk("a_busy", 64'(busy), 64'd0);

        // Crossing the stage boundary 13 -> 15
        offer(13, acc);
        push_ramp(3, 13, 13, acc);
        wait_idle("b1", 80);
        chk("b_trim13", 64'(trim), 64'h0001FFF);
        offer(15, acc);
        push_ramp(13, 15, 15, acc);
        wait_idle("b2", 40);
        chk("b_trim15", 64'(trim), 64'h0007FFF);

        // Clamp 31 -> 26, then full descent
        offer(31, acc);
        push_ramp(15, 26, 26, acc);
        wait_idle("c1", 80);
        chk("c_code_clamp", 64'(code), 64'd26);
        chk("c_trim_full", 64'(trim), 64'h3FFFFFF);
        chk("c_busy", 64'(busy), 64'd0);
        offer(0, acc);
        push_ramp(26, 0, 0, acc);
        wait_idle("c2", 200);
        chk("c_code_zero", 64'(code), 64'd0);
        chk("c_trim_zero", 64'(trim), 64'd0);

        // Retarget mid-slew: toward 10, at code 5 switch to 2 without divider reload
        offer(10, acc);
        push_ramp(0, 5, 10, acc);
        s = acc + 5 * SLEW;
        wait_code("d_reach5", 5, 60);
        offer(2, acc);
        push_ramp(5, 2, 2, s);
        wait_idle("d", 60);
        chk("d_code", 64'(code), 64'd2);

        // External trim bypass at code 7
        offer(7, acc);
        push_ramp(2, 7, 7, acc);
        wait_idle("e", 60);
        @(negedge clock);
        dco      = 1'b1;
        ext_trim = 26'h1555555;
        @(negedge clock);
        #1;
        chk("e_ext_trim", 64'(trim), 64'h1555555);
        chk("e_ext_ready", 64'(target_ready), 64'd0);
        chk("e_ext_busy", 64'(busy), 64'd0);
        chk("e_ext_code", 64'(code), 64'd7);
        dco = 1'b0;
        @(negedge clock);
        #1;
        chk("e_rel_trim", 64'(trim), 64'h000007F);
        chk("e_rel_code", 64'(code), 64'd7);
        chk("e_rel_ready", 64'(target_ready), 64'd1);

        // Drop enable at code 9 mid-slew
        offer(12, acc);
        push_ramp(7, 9, 12, acc);
        wait_code("f_reach9", 9, 40);
        chk("f_queue", 64'(q.size()), 64'd0);
        mon_on = 1'b0;
        enable = 1'b0;
        @(negedge clock);
        #1;
        chk("f_off_code", 64'(code), 64'd0);
        chk("f_off_trim", 64'(trim), 64'd0);
        chk("f_off_busy", 64'(busy), 64'd0);
        chk("f_off_ready", 64'(target_ready), 64'd0);
        enable = 1'b1;
        repeat (20) @(negedge clock);
        chk("f_after_code", 64'(code), 64'd0);
        chk("f_after_busy", 64'(busy), 64'd0);
        chk("f_after_ready", 64'(target_ready), 64'd1);
        mon_on = 1'b1;

        // Asynchronous reset at code 9 mid-slew
        offer(12, acc);
        push_ramp(0, 9, 12, acc);
        wait_code("g_reach9", 9, 60);
        chk("g_queue", 64'(q.size()), 64'd0);
        mon_on = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("g_rst_code", 64'(code), 64'd0);
        chk("g_rst_trim", 64'(trim), 64'd0);
        chk("g_rst_busy", 64'(busy), 64'd0);
        chk("g_rst_ready", 64'(target_ready), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (20) @(negedge clock);
        chk("g_after_code", 64'(code), 64'd0);
        chk("g_after_trim", 64'(trim), 64'd0);
        chk("g_after_busy", 64'(busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
